// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stage: op encodings, status bit positions
// and the default datapath width.
package alu_pkg;

   localparam int WIDTH = 16;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_AND  = 2'b10,
      ALU_NOTB = 2'b11
   } alu_op_e;

   localparam int ST_Z = 0;
   localparam int ST_N = 1;
   localparam int ST_V = 2;

endpackage

// File: rtl/alu_stage_alu.sv
// Combinational ALU: one of four 16-bit operations plus Z/N/V flags.
// Overflow is only meaningful for add and subtract; logic ops clear it.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   input  logic [1:0]       alu_op,
   output logic [WIDTH-1:0] result,
   output logic             z,
   output logic             n,
   output logic             v
);

   localparam int MSB = WIDTH - 1;

   // Operation select and signed-overflow detection.
   always_comb begin
      result = {WIDTH{1'b0}};
      v      = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            result = ain + bin;
            v      = (ain[MSB] == bin[MSB]) && (result[MSB] != ain[MSB]);
         end
         ALU_SUB: begin
            result = ain - bin;
            v      = (ain[MSB] != bin[MSB]) && (result[MSB] != ain[MSB]);
         end
         ALU_AND: begin
            result = ain & bin;
            v      = 1'b0;
         end
         ALU_NOTB: begin
            result = ~bin;
            v      = 1'b0;
         end
         default: begin
            result = {WIDTH{1'b0}};
            v      = 1'b0;
         end
      endcase
   end

   assign z = (result == {WIDTH{1'b0}});
   assign n = result[MSB];

endmodule

// File: rtl/alu_stage.sv
// Registered ALU stage: one-slot valid/ready buffer holding the C register
// and the {V,N,Z} status register, fed by the combinational alu.
module alu_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   input  logic [1:0]       alu_op,
   input  logic             loadc,
   input  logic             loads,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic [2:0]       status
);

   logic [WIDTH-1:0] result_s;
   logic             z_s;
   logic             n_s;
   logic             v_s;
   logic [2:0]       flags_s;
   logic             accept_s;
   logic [WIDTH-1:0] c_r;
   logic [2:0]       status_r;
   logic             out_valid_r;

   alu #(.WIDTH(WIDTH)) u_alu (
      .ain    (ain),
      .bin    (bin),
      .alu_op (alu_op),
      .result (result_s),
      .z      (z_s),
      .n      (n_s),
      .v      (v_s)
   );

   // Pack the flags into their status-register positions.
   always_comb begin
      flags_s       = 3'b000;
      flags_s[ST_Z] = z_s;
      flags_s[ST_N] = n_s;
      flags_s[ST_V] = v_s;
   end

   // A full slot can still accept when it is being drained the same cycle.
   assign in_ready = !out_valid_r || out_ready;
   assign accept_s = in_valid && in_ready;

   // Slot flag plus C/status capture; reset beats both accept and consume.
   always_ff @(posedge clk) begin
      if (reset) begin
         c_r         <= {WIDTH{1'b0}};
         status_r    <= 3'b000;
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         if (loadc) begin
            c_r <= result_s;
         end
         if (loads) begin
            status_r <= flags_s;
         end
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign c         = c_r;
   assign status    = status_r;
   assign out_valid = out_valid_r;

endmodule
